// File: rtl/sram_arb_bridge_pkg.sv
`default_nettype none
// ============================================================================
// sram_arb_bridge_pkg : owner encodings and default widths for the SRAM bridge
// Revision 1.0
// ============================================================================
package sram_arb_bridge_pkg;

  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

endpackage
`default_nettype wire

// File: rtl/sram_arb_grant.sv
`default_nettype none
// ============================================================================
// sram_arb_grant : combinational 2-way arbiter; round-robin with SRAM_ARB_RR_EN
// Revision 1.0
// ============================================================================
module sram_arb_grant
  import sram_arb_bridge_pkg::*;
(
`ifdef SRAM_ARB_RR_EN
  input  logic clk,
  input  logic reset,
`endif
  input  logic inst_req_i,
  input  logic data_req_i,
  input  logic en_i,
  output logic gnt_valid_o,
  output logic gnt_owner_o
);

`ifdef SRAM_ARB_RR_EN
  logic last_grant_q;
  logic last_grant_d;

  always_comb begin
    gnt_valid_o  = (inst_req_i | data_req_i) & en_i;
    gnt_owner_o  = OWNER_INST;
    if (inst_req_i && data_req_i) begin
      gnt_owner_o = (last_grant_q == OWNER_INST) ? OWNER_DATA : OWNER_INST;
    end else if (data_req_i) begin
      gnt_owner_o = OWNER_DATA;
    end
    last_grant_d = gnt_valid_o ? gnt_owner_o : last_grant_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= OWNER_INST;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  // Data port wins every conflict, so no history is kept.
  always_comb begin
    gnt_valid_o = (inst_req_i | data_req_i) & en_i;
    gnt_owner_o = data_req_i ? OWNER_DATA : OWNER_INST;
  end
`endif

endmodule
`default_nettype wire

// File: rtl/sram_arb_bridge.sv
`default_nettype none
// ============================================================================
// sram_arb_bridge : arbitrates inst/data masters onto a 1-cycle-latency SRAM
// Optional round-robin arbitration via SRAM_ARB_RR_EN. Revision 1.0
// ============================================================================
module sram_arb_bridge
  import sram_arb_bridge_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic                i_wr,
  input  logic [DATA_W/8-1:0] i_wstrb,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [DATA_W-1:0]   i_wdata,
  output logic                i_addr_ok,
  output logic                i_data_ok,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_wr,
  input  logic [DATA_W/8-1:0] d_wstrb,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_addr_ok,
  output logic                d_data_ok,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                sram_en,
  output logic [DATA_W/8-1:0] sram_we,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
  input  logic [DATA_W-1:0]   sram_rdata
);

  logic gnt_valid;
  logic gnt_owner;
  logic resp_valid_q, resp_valid_d;
  logic resp_owner_q, resp_owner_d;

  sram_arb_grant u_grant (
`ifdef SRAM_ARB_RR_EN
    .clk         (clk),
    .reset       (reset),
`endif
    .inst_req_i  (i_req),
    .data_req_i  (d_req),
    .en_i        (~reset),
    .gnt_valid_o (gnt_valid),
    .gnt_owner_o (gnt_owner)
  );

  always_comb begin
    i_addr_ok    = gnt_valid & (gnt_owner == OWNER_INST);
    d_addr_ok    = gnt_valid & (gnt_owner == OWNER_DATA);
    sram_en      = gnt_valid;
    sram_we      = '0;
    sram_addr    = (gnt_owner == OWNER_DATA) ? d_addr  : i_addr;
    sram_wdata   = (gnt_owner == OWNER_DATA) ? d_wdata : i_wdata;
    if (gnt_valid) begin
      if (gnt_owner == OWNER_DATA) begin
        sram_we = d_wr ? d_wstrb : '0;
      end else begin
        sram_we = i_wr ? i_wstrb : '0;
      end
    end
    resp_valid_d = gnt_valid;
    resp_owner_d = gnt_valid ? gnt_owner : resp_owner_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid_q <= 1'b0;
      resp_owner_q <= OWNER_INST;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_owner_q <= resp_owner_d;
    end
  end

  // A response captured just before reset must not leak out during reset.
  assign i_data_ok = resp_valid_q & ~reset & (resp_owner_q == OWNER_INST);
  assign d_data_ok = resp_valid_q & ~reset & (resp_owner_q == OWNER_DATA);
  assign i_rdata   = sram_rdata;
  assign d_rdata   = sram_rdata;

endmodule
`default_nettype wire

// File: tb/tb_sram_arb_bridge.sv
`default_nettype none
// ============================================================================
// tb_sram_arb_bridge : directed scoreboard bench for sram_arb_bridge
// Revision 1.0
// ============================================================================
module tb_sram_arb_bridge;

  typedef struct {
    logic        req;
    logic        wr;
    logic [3:0]  stb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic        iaok;
    logic        daok;
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wd;
  } cyc_exp_t;

  typedef struct {
    int          due;
    logic        owner;
    logic        is_rd;
    logic [31:0] rdata;
  } rsp_exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_req = 1'b0, i_wr = 1'b0, d_req = 1'b0, d_wr = 1'b0;
  logic [3:0]  i_wstrb = '0, d_wstrb = '0;
  logic [31:0] i_addr = '0, i_wdata = '0, d_addr = '0, d_wdata = '0;
  logic [31:0] sram_rdata = '0;
  logic        i_addr_ok, i_data_ok, d_addr_ok, d_data_ok, sram_en;
  logic [31:0] i_rdata, d_rdata, sram_addr, sram_wdata;
  logic [3:0]  sram_we;

  int vecs = 0;
  int errs = 0;
  int cyc = 0;
  logic started = 1'b0;
  cyc_exp_t cq[$];
  rsp_exp_t rq[$];

  sram_arb_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_req      (i_req),
    .i_wr       (i_wr),
    .i_wstrb    (i_wstrb),
    .i_addr     (i_addr),
    .i_wdata    (i_wdata),
    .i_addr_ok  (i_addr_ok),
    .i_data_ok  (i_data_ok),
    .i_rdata    (i_rdata),
    .d_req      (d_req),
    .d_wr       (d_wr),
    .d_wstrb    (d_wstrb),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_addr_ok  (d_addr_ok),
    .d_data_ok  (d_data_ok),
    .d_rdata    (d_rdata),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  function automatic req_t none();
    req_t r = '{1'b0, 1'b0, 4'h0, 32'h0, 32'h0};
    return r;
  endfunction

  // Reads carry junk strobes/data to show they are ignored.
  function automatic req_t rd(input logic [31:0] a);
    req_t r = '{1'b1, 1'b0, 4'hF, a, 32'hBAD0BAD0};
    return r;
  endfunction

  function automatic req_t wr(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    req_t r = '{1'b1, 1'b1, s, a, d};
    return r;
  endfunction

  task automatic step(input logic rst, input req_t ir, input req_t dr, input logic [31:0] srd,
                      input logic e_i, input logic e_d, input logic [3:0] e_we,
                      input logic [31:0] e_addr, input logic [31:0] e_wd, input logic [31:0] e_rd);
    cyc_exp_t ce;
    rsp_exp_t re;
    @(posedge clk);
    #1;
    started    = 1'b1;
    reset      = rst;
    i_req = ir.req; i_wr = ir.wr; i_wstrb = ir.stb; i_addr = ir.addr; i_wdata = ir.wdata;
    d_req = dr.req; d_wr = dr.wr; d_wstrb = dr.stb; d_addr = dr.addr; d_wdata = dr.wdata;
    sram_rdata = srd;
    if (rst) rq.delete();
    ce = '{e_i, e_d, e_i | e_d, e_we, e_addr, e_wd};
    cq.push_back(ce);
    if (e_i | e_d) begin
      re = '{cyc + 1, e_d, e_d ? !dr.wr : !ir.wr, e_rd};
      rq.push_back(re);
    end
  endtask

  task automatic idle(input logic [31:0] srd);
    step(1'b0, none(), none(), srd, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic rst_cyc(input req_t ir, input req_t dr);
    step(1'b1, ir, dr, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
  endtask

  // Monitor: accept-cycle outputs from cq, responses from rq.
  always @(negedge clk) begin
    if (started) begin
      if (cq.size() != 0) begin
        cyc_exp_t ce;
        ce = cq.pop_front();
        chk("i_addr_ok", {31'b0, i_addr_ok}, {31'b0, ce.iaok});
        chk("d_addr_ok", {31'b0, d_addr_ok}, {31'b0, ce.daok});
        chk("sram_en",   {31'b0, sram_en},   {31'b0, ce.en});
        chk("sram_we",   {28'b0, sram_we},   {28'b0, ce.we});
        if (ce.en) chk("sram_addr", sram_addr, ce.addr);
        if (ce.we != 4'h0) chk("sram_wdata", sram_wdata, ce.wd);
      end
      if (i_data_ok && d_data_ok) chk("dual_data_ok", 32'h1, 32'h0);
      if (rq.size() != 0 && rq[0].due == cyc) begin
        rsp_exp_t re;
        re = rq.pop_front();
        chk("i_data_ok", {31'b0, i_data_ok}, {31'b0, re.owner == 1'b0});
        chk("d_data_ok", {31'b0, d_data_ok}, {31'b0, re.owner == 1'b1});
        if (re.is_rd) chk("rdata", re.owner ? d_rdata : i_rdata, re.rdata);
      end else begin
        chk("i_data_ok_idle", {31'b0, i_data_ok}, 32'h0);
        chk("d_data_ok_idle", {31'b0, d_data_ok}, 32'h0);
      end
    end
  end

  initial begin
    rst_cyc(none(), none());
    rst_cyc(none(), none());

    // Single inst read, then single data write.
    step(1'b0, rd(32'h1C000000), none(), 32'h0, 1'b1, 1'b0, 4'h0, 32'h1C000000, 32'h0, 32'h02800C0C);
    idle(32'h02800C0C);
    step(1'b0, none(), wr(32'h100, 4'h3, 32'hDEADBEEF), 32'h0, 1'b0, 1'b1, 4'h3, 32'h100, 32'hDEADBEEF, 32'h0);
    idle(32'h0);

    // Conflict for four cycles from a fresh last_grant.
    rst_cyc(none(), none());
`ifdef SRAM_ARB_RR_EN
    step(1'b0, rd(32'h40), rd(32'h80), 32'h0,        1'b0, 1'b1, 4'h0, 32'h80, 32'h0, 32'hA0A0A0A0);
    step(1'b0, rd(32'h40), rd(32'h80), 32'hA0A0A0A0, 1'b1, 1'b0, 4'h0, 32'h40, 32'h0, 32'hA1A1A1A1);
    step(1'b0, rd(32'h40), rd(32'h80), 32'hA1A1A1A1, 1'b0, 1'b1, 4'h0, 32'h80, 32'h0, 32'hA2A2A2A2);
    step(1'b0, rd(32'h40), rd(32'h80), 32'hA2A2A2A2, 1'b1, 1'b0, 4'h0, 32'h40, 32'h0, 32'hA3A3A3A3);
`else
    step(1'b0, rd(32'h40), rd(32'h80), 32'h0,        1'b0, 1'b1, 4'h0, 32'h80, 32'h0, 32'hA0A0A0A0);
    step(1'b0, rd(32'h40), rd(32'h80), 32'hA0A0A0A0, 1'b0, 1'b1, 4'h0, 32'h80, 32'h0, 32'hA1A1A1A1);
    step(1'b0, rd(32'h40), rd(32'h80), 32'hA1A1A1A1, 1'b0, 1'b1, 4'h0, 32'h80, 32'h0, 32'hA2A2A2A2);
    step(1'b0, rd(32'h40), rd(32'h80), 32'hA2A2A2A2, 1'b0, 1'b1, 4'h0, 32'h80, 32'h0, 32'hA3A3A3A3);
`endif
    idle(32'hA3A3A3A3);

    // Back-to-back inst reads.
    step(1'b0, rd(32'h0), none(), 32'h0,        1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 32'h11111111);
    step(1'b0, rd(32'h4), none(), 32'h11111111, 1'b1, 1'b0, 4'h0, 32'h4, 32'h0, 32'h22222222);
    step(1'b0, rd(32'h8), none(), 32'h22222222, 1'b1, 1'b0, 4'h0, 32'h8, 32'h0, 32'h33333333);
    idle(32'h33333333);

    // Reset right after an accept drops the in-flight response.
    step(1'b0, none(), rd(32'h200), 32'h0, 1'b0, 1'b1, 4'h0, 32'h200, 32'h0, 32'h0);
    rst_cyc(rd(32'h300), rd(32'h400));
    rst_cyc(rd(32'h300), rd(32'h400));
    idle(32'h55555555);

    // Zero-strobe data write still completes; inst write strobes pass through.
    step(1'b0, none(), wr(32'h10, 4'h0, 32'h12345678), 32'h0, 1'b0, 1'b1, 4'h0, 32'h10, 32'h0, 32'h0);
    step(1'b0, wr(32'h20, 4'hC, 32'hCAFEF00D), none(), 32'h0, 1'b1, 1'b0, 4'hC, 32'h20, 32'hCAFEF00D, 32'h0);
    idle(32'h0);

    for (int i = 0; i < 10; i++) idle(32'hFFFFFFFF);

    @(negedge clk);
    chk("rsp_queue_drained", rq.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
`default_nettype wire
